// File: rtl/mem_stream_tx_pkg.sv
// mem_stream_tx_pkg: frame FSM states and datapath widths shared by mem_stream_tx.
package mem_stream_tx_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam int SUM_W  = 24;
  localparam int CNT_W  = 64;
endpackage

// File: rtl/mem_stream_tx.sv
// mem_stream_tx: snapshots a byte memory on start and streams it one byte per accepted beat.
// Define MEM_TX_SUM_EN to add the per-frame modulo-2^24 byte sum on sum_24bit.
module mem_stream_tx
  import mem_stream_tx_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_mem_8bit [0:DEPTH-1],
  output logic [BYTE_W-1:0] out_8bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_64bit,
  output logic [SUM_W-1:0]  sum_24bit
);
  state_t            r_state, w_next;
  logic [BYTE_W-1:0] r_snap [0:DEPTH-1];
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_sent;
  logic              w_start, w_beat, w_last;
  assign w_start = (r_state == IDLE) && start;
  assign w_beat  = (r_state == SEND) && out_ready;
  assign w_last  = r_idx == IDX_W'(DEPTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? SEND : IDLE) :
             (r_state == SEND) ? ((out_ready && w_last) ? DONE : SEND) : IDLE;
  end
  // Index wraps to 0 on the final beat so it never exceeds DEPTH-1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_snap[i] <= '0;
      r_idx  <= '0;
      r_sent <= '0;
    end else if (w_start) begin
      r_snap <= in_mem_8bit;
      r_idx  <= '0;
    end else if (w_beat) begin
      r_sent <= r_sent + 1'b1;
      r_idx  <= w_last ? '0 : r_idx + 1'b1;
    end
  assign out_8bit   = (r_state == SEND) ? r_snap[r_idx] : '0;
  assign out_valid  = r_state == SEND;
  assign out_last   = (r_state == SEND) && w_last;
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
  assign sent_64bit = r_sent;
`ifdef MEM_TX_SUM_EN
  logic [SUM_W-1:0] r_sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_beat)  r_sum <= r_sum + SUM_W'(out_8bit);
  assign sum_24bit = r_sum;
`else
  assign sum_24bit = '0;
`endif
endmodule

// File: tb/tb_mem_stream_tx.sv
// tb_mem_stream_tx: randomized frame tests of mem_stream_tx against a queue-free array reference model.
module tb_mem_stream_tx;
  localparam int DEPTH = 10;
`ifdef MEM_TX_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif
  logic        clk = 1'b0, rst_n, start, out_ready;
  logic [7:0]  mem [0:DEPTH-1];
  logic [7:0]  out_8bit;
  logic        out_valid, out_last, busy, done;
  logic [63:0] sent_64bit;
  logic [23:0] sum_24bit;
  int          tests = 0, fails = 0, done_seen = 0;
  logic [63:0] m_sent = '0;
  logic [23:0] m_sum = '0;

  mem_stream_tx #(.DEPTH(DEPTH), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_mem_8bit(mem),
    .out_8bit(out_8bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done),
    .sent_64bit(sent_64bit), .sum_24bit(sum_24bit));

  always #5 clk = ~clk;

  task automatic rand_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_idle_zero(input string tag);
    tests++;
    if ({out_8bit, out_valid, out_last, busy, done} !== 12'd0) begin
      fails++;
      $display("FAIL %s outputs: data=%h valid=%b last=%b busy=%b done=%b required all 0",
               tag, out_8bit, out_valid, out_last, busy, done);
    end
  endtask

  // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random. chg_at: beat index at which mem becomes FF.
  task automatic send_frame(input int mode, input int chg_at, input bit hold);
    logic [7:0]  exp [0:DEPTH-1];
    logic [23:0] es;
    int idx = 0, cyc = 0;
    exp = mem;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    m_sum = '0;
    while (idx < DEPTH && cyc < 200) begin
      if (idx == chg_at) for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      tests++;
      if (out_valid !== 1'b1 || out_8bit !== exp[idx] || out_last !== (idx == DEPTH - 1) || busy !== 1'b1) begin
        fails++;
        $display("FAIL beat[%0d] cyc %0d: valid=%b data=%h last=%b busy=%b required 1 %h %b 1",
                 idx, cyc, out_valid, out_8bit, out_last, busy, exp[idx], idx == DEPTH - 1);
      end
      if (out_ready) begin
        m_sent++;
        m_sum += 24'(exp[idx]);
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    es = SUM_ON ? m_sum : 24'd0;
    tests++;
    if (idx < DEPTH) begin
      fails++;
      $display("FAIL frame timeout: %0d beats of %0d", idx, DEPTH);
    end
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL done cycle: done=%b valid=%b busy=%b last=%b required 1 0 1 0", done, out_valid, busy, out_last);
    end
    if (done === 1'b1) done_seen++;
    tests++;
    if (sent_64bit !== m_sent || sum_24bit !== es) begin
      fails++;
      $display("FAIL counters: sent=%0h sum=%h required %0h %h", sent_64bit, sum_24bit, m_sent, es);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after done: done=%b valid=%b busy=%b required 0 0 0", done, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    check_idle_zero("reset");
    tests++;
    if (sent_64bit !== 64'd0 || sum_24bit !== 24'd0) begin
      fails++;
      $display("FAIL reset counters: sent=%0h sum=%h required 0 0", sent_64bit, sum_24bit);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("idle after release");
  endtask

  task automatic test_basic();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 1);
    send_frame(0, -1, 1'b0);
    tests++;
    if (sent_64bit !== 64'd10 || sum_24bit !== (SUM_ON ? 24'd55 : 24'd0)) begin
      fails++;
      $display("FAIL basic totals: sent=%0d sum=%0d required 10 %0d", sent_64bit, sum_24bit, SUM_ON ? 55 : 0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 1);
    send_frame(1, -1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rand_mem();
      send_frame(2, -1, 1'b0);
    end
  endtask

  task automatic test_snapshot();
    rand_mem();
    send_frame(2, 5, 1'b0);
    send_frame(0, -1, 1'b0);
    tests++;
    if (sum_24bit !== (SUM_ON ? 24'h0009F6 : 24'd0)) begin
      fails++;
      $display("FAIL FF frame sum: got %h required %h", sum_24bit, SUM_ON ? 24'h0009F6 : 24'd0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    logic [63:0] s0 = m_sent;
    for (int k = 0; k < 3; k++) begin
      rand_mem();
      send_frame(0, -1, 1'b1);
    end
    start = 1'b0;
    tests++;
    if (done_seen - d0 !== 3 || sent_64bit - s0 !== 64'd30) begin
      fails++;
      $display("FAIL back_to_back: done pulses=%0d beats=%0d required 3 30", done_seen - d0, sent_64bit - s0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rand_mem();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    out_ready = 1'b0;
    m_sent = '0;
    m_sum = '0;
    check_idle_zero("mid-frame reset");
    tests++;
    if (sent_64bit !== 64'd0 || sum_24bit !== 24'd0) begin
      fails++;
      $display("FAIL mid reset counters: sent=%0h sum=%h required 0 0", sent_64bit, sum_24bit);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_mem();
    send_frame(2, -1, 1'b0);
  endtask

  task automatic test_wrap();
    force dut.r_sent = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.r_sent;
    m_sent = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    rand_mem();
    send_frame(0, -1, 1'b0);
    tests++;
    if (sent_64bit !== 64'd8) begin
      fails++;
      $display("FAIL wrap: sent=%0h required 8", sent_64bit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    rand_mem();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
